seq_mag_compare: RTL and testbench
==================================

Name: seq_mag_compare

Overview:
Parametrised multi-cycle magnitude comparator for the ALU datapath.
- Compares two W-bit operands one SLICE-bit slice per cycle, MSB-first, with early termination on the first differing slice.
- Supports unsigned and two's-complement signed modes.
- Returns a full relation set (gt/eq/lt/ge) through a start/busy/done handshake.
- Replaces the fixed-width combinational ≥ comparator; trades latency for area at large W.

Parameters:
W, 16, operand width in bits; must be a multiple of SLICE and ≥ 2*SLICE.
SLICE, 2, bits compared per cycle; N = W/SLICE slices.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
a  input  W  operand A; sampled with start.
b  input  W  operand B; sampled with start.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse when results become valid.
agtb  output  1  a > b.
aeqb  output  1  a == b.
altb  output  1  a < b.
ageb  output  1  a ≥ b; equals agtb | aeqb.

Behaviour:
- Reset: synchronous, active-high. Forces state IDLE, busy=0, done=0, agtb=aeqb=altb=ageb=0, slice index=0. Reset overrides start in the same cycle.
- Reset mid-compare: abort; no done pulse; result outputs cleared to 0.

States:
- IDLE → CMP on start.
  - At that edge: latch a, b and signed_mode into internal registers.
  - Set idx=N-1, busy=1.
- CMP, each cycle: compare slice idx of the latched operands with the slice_cmp sub-module.
  - Slice differs: decide gt/lt from it and go to IDLE.
  - Slices equal and idx==0: decide eq and go to IDLE.
  - Otherwise: idx decrements.
- On the decision edge: result registers load, done=1 for exactly one cycle, busy=0.

Signed rule:
- Applies on the MSB slice only (idx=N-1), when signed_mode=1 and the operand MSBs differ.
- The operand with MSB=1 is smaller; decide immediately.
- Same-sign signed operands use the unsigned comparison of the remaining bits, including the MSB slice.

Latency:
- done asserts k cycles after the start edge, where k = index of the first differing slice counted from the MSB (1..N).
- Equal operands take N cycles.

Handshake:
- start while busy=1 is ignored; operands are not re-sampled.
- start is accepted in the same cycle done=1 (busy is already 0), giving back-to-back operation.

Output holding:
- Result outputs hold their last value until the next decision edge or reset.
- They are not cleared on start.
- Exactly one of agtb/aeqb/altb is 1 after any completed compare.

Decomposition:
Shared package:
- State enum {IDLE, CMP}.
- Slice result enum {S_EQ, S_GT, S_LT}.
- Constant N = W/SLICE.
- Index width function clog2(N).

Sub-module slice_cmp (combinational):
- SLICE-bit unsigned a/b slice in; slice result out.
- Instantiated once, muxed by idx.

Top level holds:
- FSM.
- idx counter.
- Operand and mode registers.
- Result registers.
- Elaboration checks on W % SLICE == 0.

Test Plan (W=16, SLICE=2):
1. Unsigned MSB decide: signed_mode=0, a=0x8000, b=0x7FFF, start 1 cycle → done 1 cycle later, agtb=1, ageb=1, aeqb=0, altb=0; busy high for 1 cycle.
2. Signed sign decide: signed_mode=1, a=0x8000, b=0x7FFF → done after 1 cycle, altb=1, ageb=0, agtb=0.
3. Full-length cases, all with done after 8 cycles:
   - Equal: a=b=0x1234, either mode → aeqb=1, ageb=1, agtb=altb=0; busy high exactly 8 cycles.
   - LSB decide, unsigned: a=0x0001, b=0x0000 → agtb=1.
   - LSB decide, signed: a=0xFFFE (-2), b=0xFFFF (-1) → altb=1.
4. Handshake:
   - Start compare 0x1234 vs 0x1234.
   - Pulse start with a=0x0000, b=0xFFFF at cycles 2 and 5 while busy → ignored; done at cycle 8 reports aeqb=1.
   - New start asserted in the done cycle with a=0x0100, b=0x0200 → accepted; done 4 cycles later with altb=1.
5. Reset mid-op: start 0x0001 vs 0x0000, assert reset at cycle 3 → next cycle busy=0, all results 0, and no done pulse for the next 10 cycles.
6. Randomised sweep: 1000 random a/b/signed_mode compared against a reference model. Check:
   - One-hot property of agtb/aeqb/altb.
   - ageb == agtb|aeqb.
   - Latency == first-differing-slice index.

Source files
------------

// File: rtl/seq_mag_compare_pkg.sv
// rtl/seq_mag_compare_pkg.sv - shared types, defaults and sizing helpers for seq_mag_compare
//
// Purpose:
//   Types shared by the sequential magnitude comparator and its slice
//   comparator. The top-level FSM uses state_e. The combinational slice
//   comparator returns slice_res_e. The helper functions size the slice
//   count and the slice index counter from the W/SLICE parameters.
//
// Contents:
//   DEFAULT_W, DEFAULT_SLICE  default operand width and slice width
//   state_e                   {IDLE, CMP}
//   slice_res_e               {S_EQ, S_GT, S_LT}
//   num_slices(w, slice)      N = w / slice
//   idx_width(n)              ceil(log2(n)), minimum 1 bit

package seq_mag_compare_pkg;

    localparam int DEFAULT_W     = 16;
    localparam int DEFAULT_SLICE = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        S_EQ = 2'd0,
        S_GT = 2'd1,
        S_LT = 2'd2
    } slice_res_e;

    function automatic int num_slices(input int w, input int slice);
        return w / slice;
    endfunction

    // Width of a counter that can hold 0..n-1. The result is never below 1
    // bit, so a single-slice index still gets a real signal.
    function automatic int idx_width(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mag_compare_slice_cmp.sv
// rtl/seq_mag_compare_slice_cmp.sv - combinational unsigned compare of one operand slice
//
// Purpose:
//   Compares one SLICE-bit slice of operand A against the matching slice of
//   operand B as unsigned values. The top level instantiates this once and
//   steers the current slice into it with the slice index.
//
// Ports:
//   a_slice  in   SLICE  slice of operand A
//   b_slice  in   SLICE  slice of operand B
//   res      out  enum   S_EQ / S_GT / S_LT, unsigned relation of a_slice to b_slice

module seq_mag_compare_slice_cmp
    import seq_mag_compare_pkg::*;
#(
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic [SLICE-1:0] a_slice,
    input  logic [SLICE-1:0] b_slice,
    output slice_res_e       res
);

    always_comb begin
        res = S_EQ;
        if (a_slice > b_slice) begin
            res = S_GT;
        end else if (a_slice < b_slice) begin
            res = S_LT;
        end
    end

endmodule

// File: rtl/seq_mag_compare.sv
// rtl/seq_mag_compare.sv - multi-cycle MSB-first magnitude comparator with start/busy/done
//
// Purpose:
//   Compares two W-bit operands one SLICE-bit slice per cycle, starting at
//   the most significant slice. The compare stops on the first slice that
//   differs. Signed mode settles opposite-sign operands on the first slice
//   from the operand MSBs alone. All outputs are registered.
//
// Ports:
//   clk          in   1  rising-edge clock
//   reset        in   1  synchronous, active-high; aborts any compare and clears results
//   start        in   1  compare request, accepted only while busy = 0
//   signed_mode  in   1  1 = two's-complement, 0 = unsigned; sampled with start
//   a, b         in   W  operands; sampled with start
//   busy         out  1  compare in progress
//   done         out  1  one-cycle pulse when the result registers are loaded
//   agtb         out  1  a > b
//   aeqb         out  1  a == b
//   altb         out  1  a < b
//   ageb         out  1  a >= b (agtb | aeqb)

module seq_mag_compare
    import seq_mag_compare_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb,
    output logic         ageb
);

    localparam int N     = num_slices(W, SLICE);
    localparam int IDX_W = idx_width(N);

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

    generate
        if ((W % SLICE) != 0 || W < 2 * SLICE) begin : g_bad_params
            $error("seq_mag_compare: W must be a multiple of SLICE and at least 2*SLICE");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, operand, mode and result registers
    // ------------------------------------------------------------------
    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic             signed_q, signed_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             agtb_q,   agtb_d;
    logic             aeqb_q,   aeqb_d;
    logic             altb_q,   altb_d;
    logic             ageb_q,   ageb_d;

    // ------------------------------------------------------------------
    // Slice steering: split the latched operands into N slices, where
    // slice 0 is the least significant. The single comparator sees the
    // slice picked by idx_q.
    // ------------------------------------------------------------------
    logic [SLICE-1:0] a_slices [N];
    logic [SLICE-1:0] b_slices [N];

    for (genvar i = 0; i < N; i++) begin : g_slices
        assign a_slices[i] = a_q[i*SLICE +: SLICE];
        assign b_slices[i] = b_q[i*SLICE +: SLICE];
    end

    slice_res_e slice_res;

    seq_mag_compare_slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a_slice (a_slices[idx_q]),
        .b_slice (b_slices[idx_q]),
        .res     (slice_res)
    );

    // In signed mode, operands whose sign bits differ are ordered by sign
    // alone. This only matters on the MSB slice. Operands with the same
    // sign compare correctly as unsigned values, MSB slice included.
    logic sign_split;
    assign sign_split = signed_q && (idx_q == IDX_MSB) && (a_q[W-1] != b_q[W-1]);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic       decide;
    slice_res_e verdict;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        agtb_d   = agtb_q;
        aeqb_d   = aeqb_q;
        altb_d   = altb_q;
        ageb_d   = ageb_q;
        decide   = 1'b0;
        verdict  = S_EQ;

        case (state_q)
            IDLE: begin
                // The result registers keep their old values here. A new
                // start does not clear them; they change only when the new
                // compare reaches its decision.
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = signed_mode;
                    idx_d    = IDX_MSB;
                    busy_d   = 1'b1;
                    state_d  = CMP;
                end
            end

            CMP: begin
                if (sign_split) begin
                    decide  = 1'b1;
                    verdict = a_q[W-1] ? S_LT : S_GT;
                end else if (slice_res != S_EQ) begin
                    decide  = 1'b1;
                    verdict = slice_res;
                end else if (idx_q == '0) begin
                    decide  = 1'b1;
                    verdict = S_EQ;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // On the decision edge, busy drops and done pulses together. A start
        // can therefore be accepted in the same cycle that done is high.
        if (decide) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            agtb_d  = (verdict == S_GT);
            aeqb_d  = (verdict == S_EQ);
            altb_d  = (verdict == S_LT);
            ageb_d  = (verdict != S_LT);
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset takes priority over start, and it also cancels a
    // compare in flight without a done pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            agtb_q   <= 1'b0;
            aeqb_q   <= 1'b0;
            altb_q   <= 1'b0;
            ageb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            agtb_q   <= agtb_d;
            aeqb_q   <= aeqb_d;
            altb_q   <= altb_d;
            ageb_q   <= ageb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign agtb = agtb_q;
    assign aeqb = aeqb_q;
    assign altb = altb_q;
    assign ageb = ageb_q;

endmodule

// File: tb/tb_seq_mag_compare.sv
// tb/tb_seq_mag_compare.sv - self-checking bench for seq_mag_compare

module tb_seq_mag_compare;

    localparam int W     = 16;
    localparam int SLICE = 2;
    localparam int N     = W / SLICE;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         agtb;
    logic         aeqb;
    logic         altb;
    logic         ageb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_mag_compare #(
        .W     (W),
        .SLICE (SLICE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .agtb        (agtb),
        .aeqb        (aeqb),
        .altb        (altb),
        .ageb        (ageb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: position (1..N, counted from the MSB) of the first slice
    // that differs, or N when the operands are equal.
    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < N; i++) begin
            if (x[W-1-i*SLICE -: SLICE] != y[W-1-i*SLICE -: SLICE]) begin
                return i + 1;
            end
        end
        return N;
    endfunction

    // Reference relation as {agtb, aeqb, altb, ageb}, from plain integer compare.
    function automatic logic [3:0] ref_rel(input logic sm, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint xv;
        longint yv;
        xv = sm ? longint'($signed(x)) : longint'(x);
        yv = sm ? longint'($signed(y)) : longint'(y);
        if (xv > yv) begin
            return 4'b1001;
        end else if (xv == yv) begin
            return 4'b0101;
        end
        return 4'b0010;
    endfunction

    // Drives one compare and observes it; lat = -1 means done never came.
    task automatic do_compare(input logic sm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                              output int lat, output int busy_cnt, output logic done_at_accept,
                              output logic busy_at_done, output logic [3:0] res);
        signed_mode = sm;
        a           = xa;
        b           = xb;
        start       = 1'b1;
        tick();
        start          = 1'b0;
        done_at_accept = done;
        lat            = -1;
        busy_cnt       = 0;
        for (int c = 1; c <= N + 4; c++) begin
            if (busy) busy_cnt++;
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
        busy_at_done = busy;
        res          = {agtb, aeqb, altb, ageb};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        signed_mode = 1'b0;
        a = 16'h0001;
        b = 16'h0000;
        tick();
        tick();
        n_checks++;
        if ({busy, done, agtb, aeqb, altb, ageb} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_state got %b expected 000000",
                     {busy, done, agtb, aeqb, altb, ageb});
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrides_start busy got %b expected 0", busy);
        end
    endtask

    task automatic test_msb_decide();
        int lat, bc; logic da, bd; logic [3:0] res;
        do_compare(1'b0, 16'h8000, 16'h7FFF, lat, bc, da, bd, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL msb_latency got %0d expected 1", lat); end
        n_checks++;
        if (res !== 4'b1001) begin n_fail++; $display("FAIL msb_result got %b expected 1001", res); end
        n_checks++;
        if (bc !== 1) begin n_fail++; $display("FAIL msb_busy_cycles got %0d expected 1", bc); end
        n_checks++;
        if (bd !== 1'b0) begin n_fail++; $display("FAIL msb_busy_at_done got %b expected 0", bd); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse got %b expected 0", done); end
        n_checks++;
        if ({agtb, aeqb, altb, ageb} !== 4'b1001) begin
            n_fail++;
            $display("FAIL result_hold got %b expected 1001", {agtb, aeqb, altb, ageb});
        end
    endtask

    task automatic test_sign_decide();
        int lat, bc; logic da, bd; logic [3:0] res;
        do_compare(1'b1, 16'h8000, 16'h7FFF, lat, bc, da, bd, res);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL sign_latency got %0d expected 1", lat); end
        n_checks++;
        if (res !== 4'b0010) begin n_fail++; $display("FAIL sign_result got %b expected 0010", res); end
        tick();
    endtask

    task automatic test_full_length();
        logic       t_sm  [4];
        logic [15:0] t_a  [4];
        logic [15:0] t_b  [4];
        logic [3:0] t_res [4];
        int lat, bc; logic da, bd; logic [3:0] res;
        t_sm[0] = 1'b0; t_a[0] = 16'h1234; t_b[0] = 16'h1234; t_res[0] = 4'b0101;
        t_sm[1] = 1'b1; t_a[1] = 16'h1234; t_b[1] = 16'h1234; t_res[1] = 4'b0101;
        t_sm[2] = 1'b0; t_a[2] = 16'h0001; t_b[2] = 16'h0000; t_res[2] = 4'b1001;
        t_sm[3] = 1'b1; t_a[3] = 16'hFFFE; t_b[3] = 16'hFFFF; t_res[3] = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            do_compare(t_sm[i], t_a[i], t_b[i], lat, bc, da, bd, res);
            n_checks++;
            if (lat !== N) begin n_fail++; $display("FAIL full_latency[%0d] got %0d expected %0d", i, lat, N); end
            n_checks++;
            if (res !== t_res[i]) begin n_fail++; $display("FAIL full_result[%0d] got %b expected %b", i, res, t_res[i]); end
            n_checks++;
            if (bc !== N) begin n_fail++; $display("FAIL full_busy_cycles[%0d] got %0d expected %0d", i, bc, N); end
            n_checks++;
            if (da !== 1'b0) begin n_fail++; $display("FAIL full_done_at_accept[%0d] got %b expected 0", i, da); end
        end
        tick();
    endtask

    task automatic test_handshake();
        int done_at;
        signed_mode = 1'b0;
        a = 16'h1234;
        b = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1;
        for (int c = 1; c <= N + 2; c++) begin
            if (c == 2 || c == 5) begin
                start = 1'b1;
                a = 16'h0000;
                b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                done_at = c;
                break;
            end
        end
        n_checks++;
        if (done_at !== N) begin n_fail++; $display("FAIL ignored_start_latency got %0d expected %0d", done_at, N); end
        n_checks++;
        if ({agtb, aeqb, altb, ageb} !== 4'b0101) begin
            n_fail++;
            $display("FAIL ignored_start_result got %b expected 0101", {agtb, aeqb, altb, ageb});
        end
        // New start issued in the done cycle.
        a = 16'h0100;
        b = 16'h0200;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL back_to_back_accept busy got %b expected 1", busy); end
        n_checks++;
        if (aeqb !== 1'b1) begin n_fail++; $display("FAIL hold_across_start aeqb got %b expected 1", aeqb); end
        done_at = -1;
        for (int c = 1; c <= N + 2; c++) begin
            tick();
            if (done) begin
                done_at = c;
                break;
            end
        end
        n_checks++;
        if (done_at !== 4) begin n_fail++; $display("FAIL back_to_back_latency got %0d expected 4", done_at); end
        n_checks++;
        if ({agtb, aeqb, altb, ageb} !== 4'b0010) begin
            n_fail++;
            $display("FAIL back_to_back_result got %b expected 0010", {agtb, aeqb, altb, ageb});
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int dones;
        signed_mode = 1'b0;
        a = 16'h0001;
        b = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, agtb, aeqb, altb, ageb} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_midop_state got %b expected 000000",
                     {busy, done, agtb, aeqb, altb, ageb});
        end
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL reset_midop_no_done got %0d expected 0", dones); end
    endtask

    task automatic test_random();
        int lat, bc, exp_lat; logic da, bd; logic [3:0] res, exp_res;
        logic sm; logic [W-1:0] ra, rb;
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            exp_lat = ref_latency(ra, rb);
            exp_res = ref_rel(sm, ra, rb);
            do_compare(sm, ra, rb, lat, bc, da, bd, res);
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand_latency a=%h b=%h sm=%b got %0d expected %0d", ra, rb, sm, lat, exp_lat);
            end
            n_checks++;
            if (res !== exp_res) begin
                n_fail++;
                $display("FAIL rand_result a=%h b=%h sm=%b got %b expected %b", ra, rb, sm, res, exp_res);
            end
            n_checks++;
            if ($countones(res[3:1]) !== 1) begin
                n_fail++;
                $display("FAIL rand_onehot a=%h b=%h got %b expected one-hot", ra, rb, res[3:1]);
            end
            n_checks++;
            if (res[0] !== (res[3] | res[2])) begin
                n_fail++;
                $display("FAIL rand_ageb a=%h b=%h got %b expected %b", ra, rb, res[0], res[3] | res[2]);
            end
            n_checks++;
            if (bd !== 1'b0 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_handshake busy_at_done=%b done_at_accept=%b expected 0 0", bd, da);
            end
        end
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        test_reset();
        test_msb_decide();
        test_sign_decide();
        test_full_length();
        test_handshake();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
